// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - data-memory valid/ready bus between the load/store unit and memory
interface load_store_unit_if;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_wstrb, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_wstrb, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32 memory-access stage, one load/store per request; LSU_MISALIGN_TRAP_EN traps misaligned H/W
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  load_store_unit_if.master        mem,
  output logic                     rsp_valid,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_err,
  output logic                     busy
);

  // Timer only needs to reach TIMEOUT_CYCLES-1; the comparison is gated off when the timeout is 0.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t         state;
  logic [2:0]     funct3_q;
  logic [1:0]     off_q;
  logic [TW-1:0]  timer;

  logic           illegal;
  logic [3:0]     st_strb;
  logic [31:0]    st_data;
  logic [7:0]     ld_byte;
  logic [15:0]    ld_half;
  logic [31:0]    ld_data;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Classify the incoming request and build store strobes/lane-replicated data.
  always_comb begin
    illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) || (req_funct3[2] && req_we);
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_funct3[1:0] == 2'b01 && req_addr[0])
      illegal = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
      illegal = 1'b1;
`endif
    // Halves use addr[1] only and words ignore addr[1:0], so misalignment falls to natural alignment.
    case (req_funct3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << req_addr[1:0];
        st_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << {req_addr[1], 1'b0};
        st_data = {2{req_wdata[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = req_wdata;
      end
    endcase
    if (!req_we)
      st_strb = 4'b0000;
  end

  // Select the addressed byte/half from the returned word and extend per funct3.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = mem.mem_rdata[7:0];
      2'd1:    ld_byte = mem.mem_rdata[15:8];
      2'd2:    ld_byte = mem.mem_rdata[23:16];
      default: ld_byte = mem.mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem.mem_rdata;
    endcase
  end

  // Access FSM: accept in IDLE, hold the bus in BUS until ready or timeout, pulse the response in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      funct3_q      <= 3'd0;
      off_q         <= 2'd0;
      timer         <= '0;
      mem.mem_valid <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_wstrb <= 4'b0000;
      mem.mem_addr  <= 32'd0;
      mem.mem_wdata <= 32'd0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= 32'd0;
      rsp_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          if (req_valid) begin
            funct3_q <= req_funct3;
            off_q    <= req_addr[1:0];
            if (illegal) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'd0;
            end else begin
              state         <= BUS;
              mem.mem_valid <= 1'b1;
              mem.mem_we    <= req_we;
              mem.mem_wstrb <= st_strb;
              mem.mem_addr  <= {req_addr[31:2], 2'b00};
              mem.mem_wdata <= st_data;
            end
          end
        end
        BUS: begin
          if (mem.mem_ready) begin
            // Ready beats a same-cycle timeout.
            state         <= RESP;
            mem.mem_valid <= 1'b0;
            timer         <= '0;
            rsp_valid     <= 1'b1;
            rsp_err       <= 1'b0;
            rsp_rdata     <= mem.mem_we ? 32'd0 : ld_data;
          end else if (TIMEOUT_EN && timer == TIMER_LAST) begin
            state         <= RESP;
            mem.mem_valid <= 1'b0;
            timer         <= '0;
            rsp_valid     <= 1'b1;
            rsp_err       <= 1'b1;
            rsp_rdata     <= 32'd0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the RV32 core, directly downstream of the ALU: takes the ALU result as the effective address and rs2 as store data. Runs one load or store per request over a valid/ready data-memory port. Generates byte strobes and sign/zero-extends load data. Holds `busy` to stall the pipeline until the one-cycle response pulse.

## Interface
- `TIMEOUT_CYCLES`, default 16: bus-wait limit in cycles; 0 disables the timeout.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: execute stage presents an access.
- `req_ready` out 1: high exactly when state is IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32 funct3. 000 B, 001 H, 010 W, 100 BU, 101 HU. BU/HU are load-only.
- `req_addr` in 32: effective address (ALU `res`).
- `req_wdata` in 32: store data (rs2).
- `mem_valid` out 1: bus request, held until accepted.
- `mem_ready` in 1: memory accepts / completes the access in this cycle.
- `mem_we` out 1: bus write enable.
- `mem_wstrb` out 4: byte strobes. 0000 for loads.
- `mem_addr` out 32: word-aligned address, `{req_addr[31:2], 2'b00}`.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rdata` in 32: read data, valid when `mem_valid && mem_ready && !mem_we`.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data. 0 for stores and errors.
- `rsp_err` out 1: access fault. Qualified by `rsp_valid`.
- `busy` out 1: pipeline stall, equal to `state != IDLE`.

## Operation
- States: IDLE, BUS, RESP.
- **IDLE**
  - `req_valid` high latches we, funct3, addr and wdata.
  - Next state is BUS, or RESP with error if the request is illegal.
- **Illegal request (error, no bus access)**
  - funct3 is 011, 110 or 111.
  - funct3 is 100 or 101 with `req_we = 1`.
  - Misaligned, when the configuration macro is defined.
- **BUS**
  - `mem_valid` = 1; all `mem_*` outputs stay stable.
  - `mem_ready` high: capture and format `mem_rdata`, set err = 0, go to RESP.
  - Timeout: `mem_ready` still low in the TIMEOUT_CYCLES-th consecutive BUS cycle → err = 1, go to RESP. `mem_valid` drops on the next cycle.
- **RESP**: `rsp_valid` = 1 for exactly one cycle, then IDLE.
- **Store strobes and data**
  - SB: strobe `0001 << addr[1:0]`, data `{4{wdata[7:0]}}`.
  - SH: strobe `0011 << {addr[1],1'b0}`, data `{2{wdata[15:0]}}`.
  - SW: strobe 1111, data = wdata.
- **Load extraction**: select the byte at `addr[1:0]` or the half at `addr[1]`. B/H sign-extend; BU/HU zero-extend; W passes through.
- Timeout counter resets on entry to BUS and is 0 outside BUS.

## Timing
- All outputs are registered or state-decoded. No combinational path from `mem_*` inputs to `req_ready`.
- **Reset values**
  - state IDLE, `req_ready` = 1.
  - `mem_valid`, `mem_we`, `rsp_valid`, `rsp_err`, `busy` = 0.
  - `mem_wstrb` = 0000; `mem_addr`, `mem_wdata`, `rsp_rdata` = 0.
- **Best case** (request accepted at edge 0):
  - `mem_valid` high in cycle 1.
  - `mem_ready` high in cycle 1 gives `rsp_valid` in cycle 2.
  - IDLE again in cycle 3, so throughput is one request per 3 cycles minimum.
- **Error path without bus access**: `rsp_valid` in cycle 1.
- `req_valid` while not IDLE is ignored; the upstream stage holds the request because `busy` is high.
- Reset asserted mid-BUS: `mem_valid` drops immediately (asynchronous) and no response is issued.
- `mem_ready` in the same cycle the timeout fires: the ready wins and the access completes without error.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned H/HU (`addr[0]` = 1) or W (`addr[1:0]` ≠ 0) → `rsp_err` = 1.
  - Response in cycle 1; no bus cycle.
- Undefined:
  - Misalignment is silently forced to natural alignment. H ignores `addr[0]`; W ignores `addr[1:0]`.
  - The access proceeds normally with no error.

## Test plan
- SW addr 0x100, wdata 0xDEADBEEF, `mem_ready` tied 1 → `mem_addr` 0x100, `mem_wstrb` 1111, `rsp_valid` in cycle 2, `rsp_err` 0.
- SB addr 0x103, wdata 0x000000A5 → `mem_wstrb` 1000, `mem_wdata` 0xA5A5A5A5.
- LB and LBU at addr 0x202, `mem_rdata` 0x12F03456 → LB `rsp_rdata` 0xFFFFFFF0; LBU 0x000000F0.
- LH addr 0x201:
  - With the macro: `rsp_err` 1 in cycle 1 and `mem_valid` never high.
  - Without the macro: `mem_rdata` 0x8001FFFF returns 0xFFFFFFFF.
- `mem_ready` held 0 with TIMEOUT_CYCLES = 16 → `mem_valid` high exactly 16 cycles, then `rsp_err` 1. Repeat with `mem_ready` pulsed in cycle 16 → `rsp_err` 0.
- `rst_n` low during BUS → `mem_valid` 0 immediately, no `rsp_valid`, `req_ready` 1 after release. funct3 011 → `rsp_err` 1.
